// File: rtl/set_assoc_cache_ctrl_if.sv
// CPU request/response and memory byte-transfer signals of set_assoc_cache_ctrl.
// slave is the controller's view; master is the CPU/memory environment's view.
interface set_assoc_cache_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_we, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative write-back, write-allocate byte cache with true LRU,
// multi-cycle lookup/writeback/refill FSM and hit/access statistics.
module set_assoc_cache_ctrl #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 256,
  parameter int unsigned BLOCK_BYTES = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  set_assoc_cache_ctrl_if.slave bus,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     access_count
);
  localparam int unsigned OFF_W = $clog2(BLOCK_BYTES);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 32 - OFF_W - IDX_W;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StRefill, StRespond} state_t;

  state_t state;

  logic [7:0]       data_arr  [WAYS][SETS][BLOCK_BYTES];
  logic [TAG_W-1:0] tag_arr   [WAYS][SETS];
  logic             valid_arr [WAYS][SETS];
  logic             dirty_arr [WAYS][SETS];
  logic [WAY_W-1:0] age_arr   [WAYS][SETS];

  logic [31:0]      addr_q;
  logic             we_q;
  logic [7:0]       wdata_q;
  logic [WAY_W-1:0] vic_q;
  logic [OFF_W-1:0] beat_q;
  logic             req_ready_q, resp_valid_q, resp_hit_q, mem_req_q, mem_we_q;
  logic [7:0]       resp_rdata_q, mem_wdata_q;
  logic [31:0]      mem_addr_q;
  logic [CNT_W-1:0] hit_cnt_q, acc_cnt_q;

  logic [OFF_W-1:0] off, beat_nxt;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit, vic_found, last_beat, touch_en;
  logic [WAY_W-1:0] hit_way, victim, touch_way;

  assign off      = addr_q[OFF_W-1:0];
  assign idx      = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign tag      = addr_q[31 -: TAG_W];
  assign beat_nxt = beat_q + 1'b1;

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign hit_count      = hit_cnt_q;
  assign access_count   = acc_cnt_q;

  // Victim: lowest invalid way, otherwise the oldest (age WAYS-1) way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    vic_found = 1'b0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_arr[w][idx] && tag_arr[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_arr[w][idx] && !vic_found) begin
        vic_found = 1'b1;
        victim    = WAY_W'(w);
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_arr[w][idx] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  always_comb begin
    last_beat = bus.mem_ack && (beat_q == LAST);
    touch_en  = ((state == StLookup) && hit) || ((state == StRefill) && last_beat);
    touch_way = (state == StLookup) ? hit_way : vic_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      vic_q        <= '0;
      beat_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_cnt_q    <= '0;
      acc_cnt_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_arr[w][s] <= 1'b0;
          dirty_arr[w][s] <= 1'b0;
          age_arr[w][s]   <= WAY_W'(w);
        end
      end
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.req_valid) begin
            addr_q      <= bus.req_addr;
            we_q        <= bus.req_we;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            state       <= StLookup;
          end
        end
        StLookup: begin
          if (hit) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_rdata_q <= we_q ? 8'h00 : data_arr[hit_way][idx][off];
            if (we_q) dirty_arr[hit_way][idx] <= 1'b1;
            state <= StRespond;
          end else begin
            vic_q     <= victim;
            beat_q    <= '0;
            mem_req_q <= 1'b1;
            if (valid_arr[victim][idx] && dirty_arr[victim][idx]) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_arr[victim][idx], idx, {OFF_W{1'b0}}};
              mem_wdata_q <= data_arr[victim][idx][0];
              state       <= StWriteback;
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
              state      <= StRefill;
            end
          end
        end
        StWriteback: begin
          if (bus.mem_ack) begin
            if (beat_q == LAST) begin
              beat_q      <= '0;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              mem_addr_q  <= {tag, idx, {OFF_W{1'b0}}};
              state       <= StRefill;
            end else begin
              beat_q      <= beat_nxt;
              mem_addr_q  <= {tag_arr[vic_q][idx], idx, beat_nxt};
              mem_wdata_q <= data_arr[vic_q][idx][beat_nxt];
            end
          end
        end
        StRefill: begin
          if (last_beat) begin
            mem_req_q             <= 1'b0;
            valid_arr[vic_q][idx] <= 1'b1;
            dirty_arr[vic_q][idx] <= we_q;
            resp_valid_q          <= 1'b1;
            resp_hit_q            <= 1'b0;
            // The byte arriving this cycle is not yet in the data array.
            resp_rdata_q <= we_q ? 8'h00 :
                            (off == beat_q) ? bus.mem_rdata : data_arr[vic_q][idx][off];
            state <= StRespond;
          end else if (bus.mem_ack) begin
            beat_q     <= beat_nxt;
            mem_addr_q <= {tag, idx, beat_nxt};
          end
        end
        StRespond: begin
          acc_cnt_q   <= acc_cnt_q + 1'b1;
          if (resp_hit_q) hit_cnt_q <= hit_cnt_q + 1'b1;
          req_ready_q <= 1'b1;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == touch_way) begin
            age_arr[w][idx] <= '0;
          end else if (age_arr[w][idx] < age_arr[touch_way][idx]) begin
            age_arr[w][idx] <= age_arr[w][idx] + 1'b1;
          end
        end
      end
    end
  end

  // Line storage carries no reset; valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (state == StLookup && hit && we_q) begin
      data_arr[hit_way][idx][off] <= wdata_q;
    end
    if (state == StRefill && bus.mem_ack) begin
      data_arr[vic_q][idx][beat_q] <= bus.mem_rdata;
      if (beat_q == LAST) begin
        tag_arr[vic_q][idx] <= tag;
        if (we_q) data_arr[vic_q][idx][off] <= wdata_q;
      end
    end
  end
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl (2 ways, 256 sets, 8-byte lines) with a
// byte-addressed memory responder whose ack delay is adjustable.
module tb_set_assoc_cache_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] hit_count, access_count;
  int errors = 0;
  int checks = 0;
  int ack_delay = 0;

  set_assoc_cache_ctrl_if bus ();

  set_assoc_cache_ctrl #(
    .WAYS(2), .SETS(256), .BLOCK_BYTES(8), .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .hit_count(hit_count),
    .access_count(access_count)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] rd_q[$];
  logic [31:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];

  function automatic logic [7:0] mdef(input logic [31:0] a);
    return 8'h40 + {5'd0, a[2:0]} + a[15:8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks each transfer after ack_delay idle cycles.
  initial begin
    int waited;
    logic [31:0] cur_addr;
    logic [7:0]  cur_wd;
    waited = 0;
    cur_addr = '0;
    cur_wd = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !rst) begin
        if (waited == 0) begin
          cur_addr = bus.mem_addr;
          cur_wd = bus.mem_wdata;
        end else begin
          chk("mem_addr_stable", bus.mem_addr, cur_addr);
          chk("mem_wdata_stable", {24'd0, bus.mem_wdata}, {24'd0, cur_wd});
        end
        if (waited == ack_delay) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            bus.mem_rdata = 8'h00;
          end else begin
            bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : mdef(bus.mem_addr);
            rd_q.push_back(bus.mem_addr);
          end
          waited = 0;
        end else begin
          bus.mem_ack = 1'b0;
          waited++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        waited = 0;
      end
    end
  end

  task automatic do_req(input string tag, input logic [31:0] a, input logic we,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_hit,
                        input int exp_lat, input int exp_rds, input int exp_wrs);
    int n;
    int lat;
    rd_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    bus.req_we = we;
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 200);
    chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rdata"}, {24'd0, bus.resp_rdata}, {24'd0, exp_rd});
    chk({tag, "_hit"}, {31'd0, bus.resp_hit}, {31'd0, exp_hit});
    chk({tag, "_ready_busy"}, {31'd0, bus.req_ready}, 32'd0);
    chk({tag, "_reads"}, rd_q.size(), exp_rds);
    chk({tag, "_writes"}, wr_addr_q.size(), exp_wrs);
    for (int k = 0; k < rd_q.size(); k++) begin
      chk($sformatf("%s_rd_addr%0d", tag, k), rd_q[k], {a[31:3], 3'(k)});
    end
    @(negedge clk);
    chk({tag, "_resp_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic chk_cnt(input string tag, input int acc, input int hits);
    chk({tag, "_access_count"}, access_count, acc);
    chk({tag, "_hit_count"}, hit_count, hits);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_we = 1'b0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_hit", {31'd0, bus.resp_hit}, 32'd0);
    chk("rst_resp_rdata", {24'd0, bus.resp_rdata}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    chk_cnt("rst", 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Set 2 traffic: tags 0 (0x10 line), 1 (0x810 line), 2 (0x1010 line).
    do_req("ld12_miss", 32'h12, 1'b0, 8'h00, 8'h42, 1'b0, 10, 8, 0);
    chk_cnt("c1", 1, 0);
    do_req("ld15_hit", 32'h15, 1'b0, 8'h00, 8'h45, 1'b1, 2, 0, 0);
    chk_cnt("c2", 2, 1);
    do_req("st12_hit", 32'h12, 1'b1, 8'hA5, 8'h00, 1'b1, 2, 0, 0);
    chk_cnt("c3", 3, 2);
    do_req("ld812_fill", 32'h812, 1'b0, 8'h00, 8'h4A, 1'b0, 10, 8, 0);
    do_req("ld1012_dirty", 32'h1012, 1'b0, 8'h00, 8'h52, 1'b0, 18, 8, 8);
    for (int k = 0; k < wr_addr_q.size(); k++) begin
      chk($sformatf("wb_addr%0d", k), wr_addr_q[k], 32'h10 + k);
      chk($sformatf("wb_data%0d", k), {24'd0, wr_data_q[k]},
          (k == 2) ? 32'hA5 : 32'h40 + k);
    end
    chk_cnt("c5", 5, 2);

    do_req("lru_ld10", 32'h10, 1'b0, 8'h00, 8'h40, 1'b0, 10, 8, 0);
    do_req("lru_ld810", 32'h810, 1'b0, 8'h00, 8'h48, 1'b0, 10, 8, 0);
    do_req("lru_ld10_hit", 32'h10, 1'b0, 8'h00, 8'h40, 1'b1, 2, 0, 0);
    do_req("lru_ld1010", 32'h1010, 1'b0, 8'h00, 8'h50, 1'b0, 10, 8, 0);
    do_req("lru_ld10_hit2", 32'h10, 1'b0, 8'h00, 8'h40, 1'b1, 2, 0, 0);
    do_req("lru_ld810_miss", 32'h810, 1'b0, 8'h00, 8'h48, 1'b0, 10, 8, 0);
    do_req("ld12_wbdata", 32'h12, 1'b0, 8'h00, 8'hA5, 1'b1, 2, 0, 0);
    chk_cnt("c12", 12, 5);

    ack_delay = 3;
    do_req("slow_ld2034", 32'h2034, 1'b0, 8'h00, 8'h64, 1'b0, 34, 8, 0);
    chk_cnt("c13", 13, 5);
    ack_delay = 0;

    // Reset while the refill of 0x3008 is presenting byte 4.
    rd_q.delete();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h3008;
    bus.req_we = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    while (rd_q.size() < 4 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("pre_rst_reads", rd_q.size(), 4);
    #2 chk("pre_rst_mem_req", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    #1 chk("rst_mid_mem_req", {31'd0, bus.mem_req}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    end
    chk_cnt("rst_mid", 0, 0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    end
    chk("post_rst_reads", rd_q.size(), 4);
    do_req("ld3008_after_rst", 32'h3008, 1'b0, 8'h00, 8'h70, 1'b0, 10, 8, 0);
    do_req("ld12_after_rst", 32'h12, 1'b0, 8'h00, 8'hA5, 1'b0, 10, 8, 0);
    do_req("ld12_hit_after_rst", 32'h12, 1'b0, 8'h00, 8'hA5, 1'b1, 2, 0, 0);
    chk_cnt("c_end", 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/set_assoc_cache_ctrl.md
Name: set_assoc_cache_ctrl

Overview:
Parametrised N-way set-associative, write-back, write-allocate byte cache between the CPU-side request port and MainMemory. It generalises the direct-mapped single-cycle controller with configurable ways, sets and block size, true LRU replacement, and dirty tracking. It uses a multi-cycle FSM with valid/ready handshakes on both sides and keeps hit/access statistics counters in the block.

Parameters:
WAYS, 2, associativity (power of 2, ≥1)
SETS, 256, number of sets (power of 2, ≥2)
BLOCK_BYTES, 8, bytes per line (power of 2, ≥2); OFF_W=log2(BLOCK_BYTES), IDX_W=log2(SETS), TAG_W=32-OFF_W-IDX_W
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  CPU request present
req_ready  output  1  controller accepts request (high only in IDLE)
req_addr  input  32  byte address; offset=[OFF_W-1:0], index=[OFF_W+IDX_W-1:OFF_W], tag=upper TAG_W bits
req_we  input  1  1=store, 0=load
req_wdata  input  8  store byte
resp_valid  output  1  one-cycle pulse: request complete
resp_rdata  output  8  load data, valid with resp_valid (loads only; 0 for stores)
resp_hit  output  1  request hit, valid with resp_valid
mem_req  output  1  memory byte transfer request
mem_we  output  1  1=write byte, 0=read byte
mem_addr  output  32  memory byte address
mem_wdata  output  8  write byte
mem_ack  input  1  transfer done this cycle; mem_rdata valid when !mem_we
mem_rdata  input  8  read byte
hit_count  output  CNT_W  completed hits, wraps modulo 2^CNT_W
access_count  output  CNT_W  completed requests, wraps

Behaviour:
- Reset (async): state=IDLE; all valid and dirty bits 0; LRU age of way w in every set = w; counters 0; req_ready=1; resp_valid=resp_hit=mem_req=mem_we=0; resp_rdata, mem_addr, mem_wdata = 0. Data/tag arrays are not reset.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE: on req_valid&req_ready, latch addr/we/wdata and go to LOOKUP. Inputs are ignored at all other times.
- LOOKUP: compare tag against all valid ways in the set.
  - Hit: load reads byte; store writes byte and sets dirty; LRU updated; go to RESPOND.
  - Miss: choose victim = lowest-index invalid way, else the way with max age. Go to WRITEBACK if victim valid&dirty, else REFILL.
- WRITEBACK: BLOCK_BYTES byte writes with addresses {victim_tag, index, k}, k=0..BLOCK_BYTES-1 ascending. Then go to REFILL.
- REFILL: BLOCK_BYTES byte reads with addresses {req_tag, index, k}, k ascending; each mem_rdata is written into the victim line. After the last byte:
  - install tag, valid=1, dirty=0;
  - for a store, merge req_wdata at offset and set dirty=1;
  - update LRU; go to RESPOND.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the cycle mem_ack is sampled high.
  - The next byte is presented the following cycle (mem_req may stay high).
  - mem_ack while mem_req=0 is ignored.
  - mem_req is low in IDLE, LOOKUP and RESPOND.
- LRU: the accessed way's age becomes 0; ways with age < old age increment; others unchanged. Ages are always a permutation of 0..WAYS-1. With WAYS=1 the victim is always way 0.
- RESPOND: resp_valid=1 for exactly one cycle; access_count+1; hit_count+1 if hit. Return to IDLE (req_ready high next cycle).
- Latency, accept edge to resp_valid cycle:
  - hit: 2 cycles;
  - clean miss with zero-wait mem_ack: 2+BLOCK_BYTES;
  - dirty miss: 2+2·BLOCK_BYTES.
- Reset mid-operation: the transfer is abandoned immediately (mem_req drops asynchronously). The in-flight request produces no response and no counter update. All lines become invalid; dirty data is lost.
- req_valid held high across RESPOND is accepted only once IDLE is re-entered.

Test Plan:
- After reset, load 0x0000_0012, mem returns byte k=0x40+k, zero-wait ack → 8 reads at 0x10..0x17, resp_rdata=0x42, resp_hit=0, resp_valid 10 cycles after accept, access_count=1, hit_count=0.
- Load 0x0000_0015 next → no mem_req, resp_rdata=0x45, resp_hit=1, latency 2, hit_count=1.
- Store 0xA5 to 0x12 (hit), load 0x812 (way 1 fill), load 0x1012 → victim is way with 0x10 line: 8 writes to 0x10..0x17 with byte 0x12=0xA5, then 8 reads 0x1010..0x1017.
- Loads 0x10, 0x810, 0x10, then 0x1010 → 0x810 line evicted (LRU), clean so no writes; subsequent 0x10 load hits, 0x810 load misses.
- mem_ack delayed 3 cycles per byte → mem_addr/mem_wdata stable while waiting; clean miss completes 2+8·4=34 cycles after accept with correct data.
- Assert rst during REFILL byte 4 → mem_req low same cycle, no resp_valid, counters 0; after release, load of same address misses.
